// File: rtl/vga_mem_arbiter_if.sv
// Signal bundle between the display fetcher, the bus master, the shared memory and the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface vga_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic                  vga_req_i;
    logic [ADDR_W-1:0]     vga_addr_i;
    logic                  vga_gnt_o;
    logic                  vga_drop_o;
    logic                  vga_rvalid_o;
    logic [DATA_W-1:0]     vga_rdata_o;

    logic                  bus_req_i;
    logic                  bus_we_i;
    logic [ADDR_W-1:0]     bus_addr_i;
    logic [DATA_W-1:0]     bus_wdata_i;
    logic [DATA_W/8-1:0]   bus_be_i;
    logic                  bus_gnt_o;
    logic                  bus_rvalid_o;
    logic [DATA_W-1:0]     bus_rdata_o;

    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [DATA_W-1:0]     mem_wdata_o;
    logic [DATA_W/8-1:0]   mem_be_o;
    logic [DATA_W-1:0]     mem_rdata_i;

    modport slave (
        input  vga_req_i, vga_addr_i,
        output vga_gnt_o, vga_drop_o, vga_rvalid_o, vga_rdata_o,
        input  bus_req_i, bus_we_i, bus_addr_i, bus_wdata_i, bus_be_i,
        output bus_gnt_o, bus_rvalid_o, bus_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_rdata_i
    );

    modport master (
        output vga_req_i, vga_addr_i,
        input  vga_gnt_o, vga_drop_o, vga_rvalid_o, vga_rdata_o,
        output bus_req_i, bus_we_i, bus_addr_i, bus_wdata_i, bus_be_i,
        input  bus_gnt_o, bus_rvalid_o, bus_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Two-port memory arbiter: display fetches win by fixed priority, the bus wins after
// STARVE_MAX consecutive losses. Fully pipelined, 2-cycle read latency.
module vga_mem_arbiter #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 15
) (
    input logic              clk_i,
    input logic              arstn_i,
    vga_mem_arbiter_if.slave io
);
    localparam int unsigned BE_W       = DATA_W / 8;
    localparam logic [7:0]  StarveLimit = 8'(STARVE_MAX);

    typedef enum logic [1:0] {TagNone, TagVga, TagBus} tag_e;

    logic [7:0]        starve_q, starve_d;
    logic              starve_hit;
    logic              vga_gnt, bus_gnt, vga_drop;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    tag_e              tag_q, tag_d;
    logic              vga_rvalid_q, bus_rvalid_q;

    // Grants are gated by reset so nothing is accepted while the pipeline is held clear.
    always_comb begin
        starve_hit = io.bus_req_i && (starve_q == StarveLimit);
        vga_gnt    = arstn_i && io.vga_req_i && !starve_hit;
        bus_gnt    = arstn_i && io.bus_req_i && (!io.vga_req_i || starve_hit);
        vga_drop   = arstn_i && io.vga_req_i && starve_hit;

        starve_d = 8'd0;
        if (io.bus_req_i && !bus_gnt) begin
            starve_d = (starve_q >= StarveLimit) ? StarveLimit : starve_q + 8'd1;
        end
    end

    always_comb begin
        mem_en_d    = vga_gnt || bus_gnt;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        tag_d       = TagNone;
        if (vga_gnt) begin
            mem_we_d   = 1'b0;
            mem_addr_d = io.vga_addr_i;
            mem_be_d   = '1;
            tag_d      = TagVga;
        end else if (bus_gnt) begin
            mem_we_d    = io.bus_we_i;
            mem_addr_d  = io.bus_addr_i;
            mem_wdata_d = io.bus_wdata_i;
            mem_be_d    = io.bus_be_i;
            tag_d       = io.bus_we_i ? TagNone : TagBus;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            starve_q     <= 8'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            tag_q        <= TagNone;
            vga_rvalid_q <= 1'b0;
            bus_rvalid_q <= 1'b0;
        end else begin
            starve_q     <= starve_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            tag_q        <= tag_d;
            // Memory returns data the cycle after the strobe, so the tag steers it one stage later.
            vga_rvalid_q <= (tag_q == TagVga);
            bus_rvalid_q <= (tag_q == TagBus);
        end
    end

    assign io.vga_gnt_o    = vga_gnt;
    assign io.vga_drop_o   = vga_drop;
    assign io.bus_gnt_o    = bus_gnt;
    assign io.vga_rvalid_o = vga_rvalid_q;
    assign io.bus_rvalid_o = bus_rvalid_q;
    assign io.vga_rdata_o  = io.mem_rdata_i;
    assign io.bus_rdata_o  = io.mem_rdata_i;
    assign io.mem_en_o     = mem_en_q;
    assign io.mem_we_o     = mem_we_q;
    assign io.mem_addr_o   = mem_addr_q;
    assign io.mem_wdata_o  = mem_wdata_q;
    assign io.mem_be_o     = mem_be_q;
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scoreboard bench for vga_mem_arbiter: a reference model predicts grants, memory commands
// and read returns; a separate monitor compares them as the DUT presents them.
module tb_vga_mem_arbiter;
    localparam int unsigned AW   = 12;
    localparam int unsigned DW   = 32;
    localparam int unsigned BW   = DW / 8;
    localparam int unsigned SMAX = 15;

    typedef struct {
        int              stamp;
        logic            we;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
        logic [BW-1:0]   be;
    } cmd_t;

    typedef struct {
        int              stamp;
        logic            is_vga;
        logic [DW-1:0]   data;
    } ret_t;

    logic clk = 1'b0;
    logic arstn = 1'b1;
    always #5 clk = ~clk;

    vga_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) io ();

    vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk_i   (clk),
        .arstn_i (arstn),
        .io      (io)
    );

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    cmd_t cq[$];
    ret_t rq[$];

    function automatic logic [DW-1:0] minit(input int i);
        return 32'hA5C30000 + 32'(i) * 32'h00010101;
    endfunction

    // Behavioural memory: 16 words, read data one cycle after the strobe.
    logic [DW-1:0] ram [16];
    logic [DW-1:0] rdq;
    logic          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= minit(i);
            mem_init <= 1'b1;
        end else if (io.mem_en_o) begin
            if (io.mem_we_o) begin
                for (int b = 0; b < BW; b++)
                    if (io.mem_be_o[b]) ram[io.mem_addr_o[3:0]][8*b +: 8] <= io.mem_wdata_o[8*b +: 8];
            end else begin
                rdq <= ram[io.mem_addr_o[3:0]];
            end
        end
    end
    assign io.mem_rdata_i = rdq;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference state: memory image, pending bus request, consecutive bus losses.
    logic [DW-1:0] ref_mem [16];
    logic          bp = 1'b0;
    logic          bwe;
    logic [AW-1:0] baddr;
    logic [DW-1:0] bwd;
    logic [BW-1:0] bbe;
    int            losses = 0;
    int            vga_grants = 0;
    logic          dut_bgnt, dut_drop;

    task automatic bus_set(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [BW-1:0] be);
        bp = 1'b1; bwe = we; baddr = a; bwd = d; bbe = be;
    endtask

    task automatic step(input logic vr, input logic [AW-1:0] va);
        logic forced, ev, eb, ed;
        @(negedge clk);
        arstn          = 1'b1;
        io.vga_req_i   = vr;
        io.vga_addr_i  = va;
        io.bus_req_i   = bp;
        io.bus_we_i    = bwe;
        io.bus_addr_i  = baddr;
        io.bus_wdata_i = bwd;
        io.bus_be_i    = bbe;
        #1;
        forced = bp && (losses >= int'(SMAX));
        eb = bp && (!vr || forced);
        ev = vr && !forced;
        ed = vr && forced;
        dut_bgnt = io.bus_gnt_o;
        dut_drop = io.vga_drop_o;
        if (io.vga_gnt_o) vga_grants++;
        chk("vga_gnt", 64'(io.vga_gnt_o), 64'(ev));
        chk("bus_gnt", 64'(io.bus_gnt_o), 64'(eb));
        chk("vga_drop", 64'(io.vga_drop_o), 64'(ed));
        if (ev) begin
            cq.push_back('{cyc, 1'b0, va, '0, '1});
            rq.push_back('{cyc, 1'b1, ref_mem[va[3:0]]});
        end
        if (eb) begin
            cq.push_back('{cyc, bwe, baddr, bwd, bbe});
            if (bwe) begin
                for (int b = 0; b < BW; b++)
                    if (bbe[b]) ref_mem[baddr[3:0]][8*b +: 8] = bwd[8*b +: 8];
            end else begin
                rq.push_back('{cyc, 1'b0, ref_mem[baddr[3:0]]});
            end
        end
        losses = (bp && !eb) ? losses + 1 : 0;
        if (eb) bp = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        arstn = 1'b0;
        bp = 1'b0;
        losses = 0;
        io.vga_req_i = 1'b1;
        io.bus_req_i = 1'b1;
        #1;
        chk("rst_mem_en", 64'(io.mem_en_o), 64'd0);
        chk("rst_mem_we", 64'(io.mem_we_o), 64'd0);
        chk("rst_mem_addr", 64'(io.mem_addr_o), 64'd0);
        chk("rst_mem_wdata", 64'(io.mem_wdata_o), 64'd0);
        chk("rst_mem_be", 64'(io.mem_be_o), 64'd0);
        chk("rst_vga_gnt", 64'(io.vga_gnt_o), 64'd0);
        chk("rst_bus_gnt", 64'(io.bus_gnt_o), 64'd0);
        chk("rst_vga_drop", 64'(io.vga_drop_o), 64'd0);
        chk("rst_vga_rvalid", 64'(io.vga_rvalid_o), 64'd0);
        chk("rst_bus_rvalid", 64'(io.bus_rvalid_o), 64'd0);
        cq.delete();
        rq.delete();
        @(negedge clk);
        io.vga_req_i = 1'b0;
        io.bus_req_i = 1'b0;
    endtask

    // Monitor: compares memory commands at +1 and read returns at +2 against the queues.
    initial begin
        cmd_t c;
        ret_t r;
        logic [AW-1:0] last_addr;
        logic          last_we;
        logic [BW-1:0] last_be;
        last_addr = '0; last_we = 1'b0; last_be = '0;
        @(negedge arstn);
        forever begin
            @(negedge clk);
            if (!arstn) begin
                last_addr = '0; last_we = 1'b0; last_be = '0;
            end else begin
                if (cq.size() > 0 && cq[0].stamp + 1 == cyc) begin
                    c = cq.pop_front();
                    chk("mem_en", 64'(io.mem_en_o), 64'd1);
                    chk("mem_we", 64'(io.mem_we_o), 64'(c.we));
                    chk("mem_addr", 64'(io.mem_addr_o), 64'(c.addr));
                    chk("mem_be", 64'(io.mem_be_o), 64'(c.be));
                    if (c.we) chk("mem_wdata", 64'(io.mem_wdata_o), 64'(c.wdata));
                    last_addr = c.addr; last_we = c.we; last_be = c.be;
                end else begin
                    chk("mem_en_idle", 64'(io.mem_en_o), 64'd0);
                    chk("mem_addr_hold", 64'(io.mem_addr_o), 64'(last_addr));
                    chk("mem_we_hold", 64'(io.mem_we_o), 64'(last_we));
                    chk("mem_be_hold", 64'(io.mem_be_o), 64'(last_be));
                end
                if (rq.size() > 0 && rq[0].stamp + 2 == cyc) begin
                    r = rq.pop_front();
                    chk("vga_rvalid", 64'(io.vga_rvalid_o), 64'(r.is_vga));
                    chk("bus_rvalid", 64'(io.bus_rvalid_o), 64'(!r.is_vga));
                    if (r.is_vga) chk("vga_rdata", 64'(io.vga_rdata_o), 64'(r.data));
                    else          chk("bus_rdata", 64'(io.bus_rdata_o), 64'(r.data));
                end else begin
                    chk("vga_rvalid_idle", 64'(io.vga_rvalid_o), 64'd0);
                    chk("bus_rvalid_idle", 64'(io.bus_rvalid_o), 64'd0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = minit(i);
        io.vga_req_i = 1'b0; io.vga_addr_i = '0;
        io.bus_req_i = 1'b0; io.bus_we_i = 1'b0; io.bus_addr_i = '0;
        io.bus_wdata_i = '0; io.bus_be_i = '0;
        bwe = 1'b0; baddr = '0; bwd = '0; bbe = '0;

        do_reset();
        // Bus read granted in the very first cycle after reset release.
        bus_set(1'b0, 12'h005, 32'h0, 4'hF);
        step(1'b0, '0);
        chk("first_cycle_bus_gnt", 64'(dut_bgnt), 64'd1);
        repeat (2) step(1'b0, '0);

        // Partial write then read-back of the same word.
        bus_set(1'b1, 12'h003, 32'hDEADBEEF, 4'b0011);
        step(1'b0, '0);
        bus_set(1'b0, 12'h003, 32'h0, 4'hF);
        repeat (3) step(1'b0, '0);

        // Contention: display wins until it goes quiet.
        bus_set(1'b0, 12'h007, 32'h0, 4'hF);
        step(1'b1, 12'h002);
        step(1'b1, 12'h004);
        step(1'b0, '0);
        chk("contention_bus_after_vga", 64'(dut_bgnt), 64'd1);
        repeat (2) step(1'b0, '0);

        // Starvation: 15 display grants, then the bus is forced through with a drop.
        bus_set(1'b0, 12'h009, 32'h0, 4'hF);
        vga_grants = 0;
        for (int i = 0; i < 16; i++) step(1'b1, AW'(i));
        chk("starve_vga_grants", 64'(vga_grants), 64'd15);
        chk("starve_forced", 64'({dut_bgnt, dut_drop}), 64'd3);
        bus_set(1'b0, 12'h00A, 32'h0, 4'hF);
        step(1'b1, 12'h001);
        chk("starve_cleared_vga_wins", 64'(dut_bgnt), 64'd0);
        repeat (2) step(1'b0, '0);

        // Streaming: alternating display and bus reads, back to back.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) step(1'b1, AW'(i));
            else begin
                bus_set(1'b0, AW'(15 - i), 32'h0, 4'hF);
                step(1'b0, '0);
            end
        end
        repeat (3) step(1'b0, '0);

        // Reset in the cycle after a display grant discards the pending return.
        step(1'b1, 12'h006);
        do_reset();
        repeat (4) step(1'b0, '0);

        for (int n = 0; n < 400; n++) begin
            if (!bp && ($urandom % 3 == 0))
                bus_set(1'($urandom % 2), AW'($urandom % 16), $urandom, BW'($urandom));
            step(1'($urandom % 4 != 0), AW'($urandom % 16));
        end
        for (int n = 0; n < 4 && bp; n++) step(1'b0, '0);
        repeat (3) step(1'b0, '0);
        chk("scoreboard_drained", 64'(cq.size() + rq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 12, which is the memory word-address width.
REQ-002 The block SHALL take parameter DATA_W, default 32, which is the memory data width and must be a multiple of 8.
REQ-003 The block SHALL take parameter STARVE_MAX, default 15, legal range 1..255, which is the number of consecutive cycles a bus request may lose before the bus is forced to win.
REQ-004 The block SHALL have these ports, one per line (name, direction, width, meaning):
  clk_i  in  1  single clock; all logic is clocked on its rising edge
  arstn_i  in  1  asynchronous active-low reset
  vga_req_i  in  1  display fetch request, a one-cycle pulse per fetch
  vga_addr_i  in  ADDR_W  display fetch address
  vga_gnt_o  out  1  fetch accepted this cycle
  vga_drop_o  out  1  fetch rejected because the bus was forced to win
  vga_rvalid_o  out  1  fetch data valid
  vga_rdata_o  out  DATA_W  fetch data
  bus_req_i  in  1  bus access request, held until granted
  bus_we_i  in  1  1 = write, 0 = read
  bus_addr_i  in  ADDR_W  bus word address
  bus_wdata_i  in  DATA_W  bus write data
  bus_be_i  in  DATA_W/8  bus byte enables
  bus_gnt_o  out  1  bus access accepted this cycle
  bus_rvalid_o  out  1  bus read data valid
  bus_rdata_o  out  DATA_W  bus read data
  mem_en_o  out  1  memory access strobe
  mem_we_o  out  1  memory write
  mem_addr_o  out  ADDR_W  memory address
  mem_wdata_o  out  DATA_W  memory write data
  mem_be_o  out  DATA_W/8  memory byte enables
  mem_rdata_i  in  DATA_W  memory read data, valid 1 cycle after mem_en_o with mem_we_o=0

Function
REQ-005 Arbitration SHALL be combinational in cycle t; at most one of vga_gnt_o and bus_gnt_o SHALL be high in any cycle.
REQ-006 The display SHALL have fixed priority: if vga_req_i=1 and starve_cnt<STARVE_MAX, then vga_gnt_o=1 and bus_gnt_o=0.
REQ-007 If vga_req_i=0 and bus_req_i=1, then bus_gnt_o=1.
REQ-008 If bus_req_i=1 and starve_cnt==STARVE_MAX, then bus_gnt_o=1; additionally, if vga_req_i=1, vga_drop_o=1 and vga_gnt_o=0 that cycle.
REQ-009 starve_cnt (8 bits) SHALL increment, saturating at STARVE_MAX, in every cycle with bus_req_i=1 and bus_gnt_o=0, and SHALL clear in any cycle with bus_gnt_o=1 or bus_req_i=0.
REQ-010 A grant in cycle t SHALL register the command onto the mem_* outputs in cycle t+1 with mem_en_o=1; mem_en_o=0 in t+1 if there was no grant in t.
REQ-011 For a display grant, the t+1 command SHALL be mem_we_o=0, mem_addr_o=vga_addr_i, and mem_be_o all ones.
REQ-012 For a bus grant, the t+1 command SHALL carry bus_we_i, bus_addr_i, bus_wdata_i and bus_be_i as sampled in cycle t.
REQ-013 When idle, the mem_* data, address and enable outputs SHALL hold their last values; only mem_en_o drops.
REQ-014 A read tag (none/vga/bus) SHALL be registered in cycle t+1 and SHALL select the return in cycle t+2.
REQ-015 In cycle t+2, vga_rvalid_o or bus_rvalid_o SHALL be 1 for exactly one cycle, and the matching rdata output SHALL equal mem_rdata_i.
REQ-016 A bus write SHALL produce no rvalid.
REQ-017 The block SHALL fully pipeline accesses: back-to-back grants every cycle, with 2-cycle read latency and no bubbles.
REQ-018 vga_rdata_o and bus_rdata_o SHALL pass mem_rdata_i through unconditionally; consumers qualify them with rvalid.
REQ-019 bus_gnt_o SHALL be a one-cycle pulse per accepted request; the requester deasserts or presents the next request the following cycle.
REQ-020 Simultaneous vga_req_i and bus_req_i with starve_cnt<STARVE_MAX SHALL grant the display, and starve_cnt SHALL increment.

Reset
REQ-021 While arstn_i=0, the following SHALL be 0: mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, starve_cnt, the read tags, vga_gnt_o, bus_gnt_o, vga_drop_o, vga_rvalid_o and bus_rvalid_o.
REQ-022 A reset asserted mid-access SHALL discard in-flight reads: no rvalid after deassertion for pre-reset grants.
REQ-023 Grants SHALL be possible in the first cycle after arstn_i rises.

Verification
REQ-024 Bus read alone: bus_req_i=1, we=0, addr=0x005 at t -> bus_gnt_o=1 at t; mem_en_o=1, addr=0x005 at t+1; bus_rvalid_o=1 with data at t+2.
REQ-025 Contention: vga_req_i and bus_req_i both 1 at t with starve_cnt=0 -> vga_gnt_o=1, bus_gnt_o=0; bus granted the first cycle vga_req_i=0.
REQ-026 Starvation: vga_req_i=1 every cycle and bus_req_i held, STARVE_MAX=15 -> 15 display grants, then bus_gnt_o=1 and vga_drop_o=1 in the 16th cycle, starve_cnt=0 after.
REQ-027 Streaming: alternating vga/bus reads for 8 cycles -> mem_en_o high 8 consecutive cycles; each rvalid is routed to the correct requester at +2.
REQ-028 Bus write: we=1, be=4'b0011, wdata=0xDEADBEEF -> mem_we_o=1, mem_be_o=4'b0011 at t+1; no bus_rvalid_o.
REQ-029 Reset mid-read: arstn_i low in t+1 after a display grant -> all outputs 0; no vga_rvalid_o after release.
